// File: rtl/axis_frame_pkg.sv
`default_nettype none
// =============================================================================
// Module      : axis_frame_pkg
// Description : Shared types and defaults for the AXI-Stream frame sink.
// Revision    : 1.0 - initial release
// =============================================================================
package axis_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_DEPTH      = 64;
    localparam int DEFAULT_ADDR_W     = 6;
    localparam int DEFAULT_EXPECT_LEN = 64;

    localparam logic [DEFAULT_DATA_W/8-1:0] KEEP_ALL = '1;

endpackage
`default_nettype wire

// File: rtl/frame_buf_ram.sv
`default_nettype none
// =============================================================================
// Module      : frame_buf_ram
// Description : DEPTH x DATA_W simple dual-port RAM, sync write, registered read.
// Revision    : 1.0 - initial release
// =============================================================================
module frame_buf_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage carries no reset so it maps onto RAM primitives.
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_frame_sink.sv
`default_nettype none
// =============================================================================
// Module      : axis_frame_sink
// Description : Armed AXI-Stream sink capturing one frame into a buffer.
//               AXIS_FRAME_SINK_CHECKSUM_EN enables the running word checksum.
// Revision    : 1.0 - initial release
// =============================================================================
module axis_frame_sink
    import axis_frame_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int EXPECT_LEN = DEFAULT_EXPECT_LEN
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic [DATA_W/8-1:0] s_tkeep,
    input  logic                s_tlast,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic                arm,
    output logic                busy,
    output logic                done,
    output logic [31:0]         beat_count,
    output logic                length_error,
    output logic                overflow,
    output logic                keep_error,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic [31:0]         checksum
);

    localparam logic [ADDR_W:0]       c_DEPTH      = (ADDR_W + 1)'(DEPTH);
    localparam logic [32:0]           c_EXPECT_LEN = 33'(EXPECT_LEN);
    localparam logic [DATA_W/8-1:0]   c_KEEP_ALL   = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [31:0]       r_beat_count;
    logic              r_length_error;
    logic              r_overflow;
    logic              r_keep_error;
    logic              w_accept;
    logic              w_room;
    logic              w_we;
    logic              w_start;

    assign w_accept = s_tvalid && (r_state == RECV);
    assign w_room   = (r_wr_ptr < c_DEPTH);
    assign w_we     = w_accept && w_room;
    assign w_start  = (r_state == IDLE) && arm;

    always_comb begin
        w_state_nxt = r_state;
        s_tready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (arm) begin
                    w_state_nxt = RECV;
                end
            end
            RECV: begin
                s_tready = 1'b1;
                busy     = 1'b1;
                // Abort wins over a closing beat; the beat itself is still counted.
                if (!arm) begin
                    w_state_nxt = IDLE;
                end else if (w_accept && s_tlast) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!arm) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_start) begin
            r_wr_ptr       <= '0;
            r_beat_count   <= '0;
            r_length_error <= 1'b0;
            r_overflow     <= 1'b0;
            r_keep_error   <= 1'b0;
        end else if (w_accept) begin
            if (w_room) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
            if (r_beat_count != '1) begin
                r_beat_count <= r_beat_count + 32'd1;
            end
            if (s_tkeep != c_KEEP_ALL) begin
                r_keep_error <= 1'b1;
            end
            // Widened so a saturated count never aliases onto EXPECT_LEN.
            if (s_tlast) begin
                r_length_error <= (({1'b0, r_beat_count} + 33'd1) != c_EXPECT_LEN);
            end
        end
    end

    assign beat_count   = r_beat_count;
    assign length_error = r_length_error;
    assign overflow     = r_overflow;
    assign keep_error   = r_keep_error;

`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clock) begin
        if (reset || w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + 32'(s_tdata);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'd0;
`endif

    frame_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_frame_buf_ram (
        .clock (clock),
        .reset (reset),
        .we    (w_we),
        .waddr (r_wr_ptr[ADDR_W-1:0]),
        .wdata (s_tdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_sink.sv
`default_nettype none
// =============================================================================
// Module      : tb_axis_frame_sink
// Description : Directed self-checking bench for axis_frame_sink.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_axis_frame_sink;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic        arm;
    logic        busy;
    logic        done;
    logic [31:0] beat_count;
    logic        length_error;
    logic        overflow;
    logic        keep_error;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] checksum;

    int tests_run    = 0;
    int tests_failed = 0;

    axis_frame_sink dut (
        .clock        (clock),
        .reset        (reset),
        .s_tdata      (s_tdata),
        .s_tkeep      (s_tkeep),
        .s_tlast      (s_tlast),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .arm          (arm),
        .busy         (busy),
        .done         (done),
        .beat_count   (beat_count),
        .length_error (length_error),
        .overflow     (overflow),
        .keep_error   (keep_error),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .checksum     (checksum)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] exp_ck(input logic [31:0] v);
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    // Arms, then streams n beats of base+i; tlast on last_idx (-1 = none).
    task automatic send_frame(input int n, input logic [31:0] base, input bit gapped,
                              input int bad_idx, input int last_idx);
        arm = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            if (gapped && i > 0) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                tick();
            end
            s_tvalid = 1'b1;
            s_tdata  = base + 32'(i);
            s_tkeep  = (i == bad_idx) ? 4'h7 : 4'hF;
            s_tlast  = (i == last_idx);
            tests_run++;
            if (s_tready !== 1'b1 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL beat_ready beat %0d: got tready=%b done=%b, expected tready=1 done=0",
                         i, s_tready, done);
            end
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tkeep  = 4'hF;
    endtask

    task automatic test_reset;
        reset = 1'b1; arm = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        s_tkeep = 4'hF; s_tdata = '0; rd_addr = '0;
        tick(); tick();
        tests_run++;
        if ({s_tready, busy, done, length_error, overflow, keep_error} !== 6'b0 ||
            beat_count !== 32'd0 || rd_data !== 32'd0 || checksum !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b busy=%b done=%b le=%b of=%b ke=%b cnt=%0d rd=%0h ck=%0h, expected all 0",
                     s_tready, busy, done, length_error, overflow, keep_error, beat_count, rd_data, checksum);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (s_tready !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_not_ready: got tready=%b busy=%b, expected 0 0", s_tready, busy);
        end
    endtask

    task automatic test_normal;
        logic [31:0] d;
        send_frame(64, 32'd0, 1'b0, -1, 63);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || s_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_done: got done=%b busy=%b tready=%b, expected 1 0 0", done, busy, s_tready);
        end
        tests_run++;
        if (beat_count !== 32'd64 || {length_error, overflow, keep_error} !== 3'b000) begin
            tests_failed++;
            $display("FAIL normal_status: got cnt=%0d le=%b of=%b ke=%b, expected 64 0 0 0",
                     beat_count, length_error, overflow, keep_error);
        end
        tests_run++;
        if (checksum !== exp_ck(32'd2016)) begin
            tests_failed++;
            $display("FAIL normal_checksum: got %0d, expected %0d", checksum, exp_ck(32'd2016));
        end
        rd(6'd10, d);
        tests_run++;
        if (d !== 32'd10) begin
            tests_failed++;
            $display("FAIL normal_read10: got %0h, expected a", d);
        end
    endtask

    task automatic test_short;
        arm = 1'b0;
        tick();
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_disarm: got done=%b, expected 0", done);
        end
        send_frame(10, 32'd100, 1'b0, -1, 9);
        tests_run++;
        if (done !== 1'b1 || beat_count !== 32'd10 || length_error !== 1'b1 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_status: got done=%b cnt=%0d le=%b of=%b, expected 1 10 1 0",
                     done, beat_count, length_error, overflow);
        end
        tests_run++;
        if (checksum !== exp_ck(32'd1045)) begin
            tests_failed++;
            $display("FAIL short_checksum: got %0d, expected %0d", checksum, exp_ck(32'd1045));
        end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        arm = 1'b0;
        tick();
        send_frame(70, 32'h1000, 1'b0, -1, 69);
        tests_run++;
        if (done !== 1'b1 || beat_count !== 32'd70 || overflow !== 1'b1 || length_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_status: got done=%b cnt=%0d of=%b le=%b, expected 1 70 1 1",
                     done, beat_count, overflow, length_error);
        end
        tests_run++;
        if (checksum !== exp_ck(32'd289135)) begin
            tests_failed++;
            $display("FAIL overflow_checksum: got %0d, expected %0d", checksum, exp_ck(32'd289135));
        end
        rd(6'd63, d);
        tests_run++;
        if (d !== 32'h103F) begin
            tests_failed++;
            $display("FAIL overflow_buf63: got %0h, expected 103f", d);
        end
        rd(6'd0, d);
        tests_run++;
        if (d !== 32'h1000) begin
            tests_failed++;
            $display("FAIL overflow_buf0: got %0h, expected 1000", d);
        end
    endtask

    task automatic test_gapped_keep;
        logic [31:0] d;
        arm = 1'b0;
        tick();
        send_frame(64, 32'hA000, 1'b1, 5, 63);
        tests_run++;
        if (done !== 1'b1 || beat_count !== 32'd64 || keep_error !== 1'b1 ||
            length_error !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL gapped_status: got done=%b cnt=%0d ke=%b le=%b of=%b, expected 1 64 1 0 0",
                     done, beat_count, keep_error, length_error, overflow);
        end
        tests_run++;
        if (checksum !== exp_ck(32'd2623456)) begin
            tests_failed++;
            $display("FAIL gapped_checksum: got %0d, expected %0d", checksum, exp_ck(32'd2623456));
        end
        rd(6'd5, d);
        tests_run++;
        if (d !== 32'hA005) begin
            tests_failed++;
            $display("FAIL gapped_buf5: got %0h, expected a005", d);
        end
    endtask

    task automatic test_rearm;
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hEEEE_0000 + 32'(i);
            s_tlast  = (i == 4);
            tests_run++;
            if (s_tready !== 1'b0 || done !== 1'b1) begin
                tests_failed++;
                $display("FAIL rearm_hold cycle %0d: got tready=%b done=%b, expected 0 1", i, s_tready, done);
            end
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tests_run++;
        if (beat_count !== 32'd64) begin
            tests_failed++;
            $display("FAIL rearm_count_held: got %0d, expected 64", beat_count);
        end
        arm = 1'b0;
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || keep_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL rearm_idle: got done=%b busy=%b ke=%b, expected 0 0 1", done, busy, keep_error);
        end
        send_frame(64, 32'hB000, 1'b0, -1, 63);
        tests_run++;
        if (done !== 1'b1 || beat_count !== 32'd64 || {length_error, overflow, keep_error} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rearm_second: got done=%b cnt=%0d le=%b of=%b ke=%b, expected 1 64 0 0 0",
                     done, beat_count, length_error, overflow, keep_error);
        end
        tests_run++;
        if (checksum !== exp_ck(32'd2885600)) begin
            tests_failed++;
            $display("FAIL rearm_checksum: got %0d, expected %0d", checksum, exp_ck(32'd2885600));
        end
        rd(6'd63, d);
        tests_run++;
        if (d !== 32'hB03F) begin
            tests_failed++;
            $display("FAIL rearm_buf63: got %0h, expected b03f", d);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        arm = 1'b0;
        tick();
        send_frame(20, 32'hD000, 1'b0, 7, -1);
        tests_run++;
        if (busy !== 1'b1 || beat_count !== 32'd20 || keep_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL midframe_pre: got busy=%b cnt=%0d ke=%b, expected 1 20 1", busy, beat_count, keep_error);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if ({s_tready, busy, done, length_error, overflow, keep_error} !== 6'b0 ||
            beat_count !== 32'd0 || checksum !== 32'd0) begin
            tests_failed++;
            $display("FAIL midframe_reset: got rdy=%b busy=%b done=%b le=%b of=%b ke=%b cnt=%0d ck=%0h, expected all 0",
                     s_tready, busy, done, length_error, overflow, keep_error, beat_count, checksum);
        end
        reset = 1'b0;
        arm   = 1'b0;
        tick();
        send_frame(64, 32'hC000, 1'b0, -1, 63);
        tests_run++;
        if (done !== 1'b1 || beat_count !== 32'd64 || {length_error, overflow, keep_error} !== 3'b000) begin
            tests_failed++;
            $display("FAIL midframe_fresh: got done=%b cnt=%0d le=%b of=%b ke=%b, expected 1 64 0 0 0",
                     done, beat_count, length_error, overflow, keep_error);
        end
        tests_run++;
        if (checksum !== exp_ck(32'd3147744)) begin
            tests_failed++;
            $display("FAIL midframe_checksum: got %0d, expected %0d", checksum, exp_ck(32'd3147744));
        end
        rd(6'd20, d);
        tests_run++;
        if (d !== 32'hC014) begin
            tests_failed++;
            $display("FAIL midframe_buf20: got %0h, expected c014", d);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_short();
        test_overflow();
        test_gapped_keep();
        test_rearm();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_frame_sink.md
Name: axis_frame_sink

Overview:
- AXI-Stream receiver (slave) that captures one frame into an internal buffer. It is the counterpart of the team's 64-beat stream transmitter.
- Software arms it via a GPIO bit, then reads status and captured words back through a registered read port.
- Sits on the DMA path, between the stream interconnect (MM2S side) and the GPIO/debug readout.

Parameters:
- DATA_W, 32, stream and buffer word width.
- DEPTH, 64, buffer depth in words.
- ADDR_W, 6, buffer address width; equals clog2(DEPTH).
- EXPECT_LEN, 64, expected beats per frame, used for the length check.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_tdata  in  DATA_W  stream data.
- s_tkeep  in  DATA_W/8  byte enables; only all-ones is legal.
- s_tlast  in  1  last beat of frame.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  sink ready.
- arm  in  1  level request to capture one frame (GPIO bit 0).
- busy  out  1  state is RECV.
- done  out  1  frame captured; state is DONE.
- beat_count  out  32  beats accepted in the current/last frame, saturating.
- length_error  out  1  last frame's beat count != EXPECT_LEN.
- overflow  out  1  beats beyond DEPTH were dropped.
- keep_error  out  1  a beat with s_tkeep != all-ones was accepted.
- rd_addr  in  ADDR_W  buffer read address.
- rd_data  out  DATA_W  buffer word; one-cycle registered latency.
- checksum  out  32  running sum of accepted words (see Optional Feature).

Behaviour:
- Reset values: state IDLE; s_tready=0, busy=0, done=0, beat_count=0, all error flags=0, wr_ptr=0, rd_data=0, checksum=0. Buffer contents are not reset.
- Reset mid-frame: returns to IDLE in the next cycle. Any partial frame is discarded and the status above is restored.
- Accept condition: s_tvalid && s_tready, sampled on the clock edge.
- IDLE:
  - s_tready=0.
  - If arm=1: clear beat_count, wr_ptr, all flags and checksum; go to RECV.
  - Status from the previous frame is held until the next arm.
- RECV:
  - s_tready=1 combinationally from state; no dependence on s_tvalid.
  - On each accept:
    - If wr_ptr < DEPTH: write s_tdata to buffer[wr_ptr] and increment wr_ptr. wr_ptr is ADDR_W+1 bits and never wraps.
    - Otherwise set overflow; the data is dropped.
    - beat_count += 1, saturating at 0xFFFFFFFF.
    - If s_tkeep != all-ones: set keep_error; the data is still stored.
  - Accept with s_tlast=1:
    - Set length_error iff (beat_count+1) != EXPECT_LEN, evaluated with the pre-increment count.
    - Go to DONE.
  - arm dropping to 0 in RECV (abort): go to IDLE; flags and count retained; done stays 0.
- DONE:
  - s_tready=0, done=1.
  - When arm=0, go to IDLE and drop done. While arm stays 1, no new frame is accepted (one frame per arm pulse).
- Latency: the first beat can be accepted in the cycle after arm is sampled high. done rises in the cycle after the tlast beat is accepted.
- Read port:
  - rd_data <= buffer[rd_addr] every cycle, in any state.
  - A read of the address written in the same cycle returns the old data (read-before-write).
- Simultaneous arm rising and s_tvalid in IDLE: the beat is not accepted because s_tready=0 that cycle.

Optional Feature:
- Macro: AXIS_FRAME_SINK_CHECKSUM_EN.
- Defined: checksum accumulates the modulo-2^32 sum of every accepted s_tdata, including dropped overflow beats. It is cleared on arm in IDLE and held in DONE/IDLE.
- Undefined: checksum is tied to 0 and no adder is synthesised. The port stays present so the top level is unchanged.

Decomposition:
- Package axis_frame_pkg:
  - state enum {IDLE, RECV, DONE}.
  - KEEP_ALL constant.
  - Default DEPTH/EXPECT_LEN constants shared with the transmitter.
- Sub-module frame_buf_ram: DEPTH x DATA_W simple dual-port RAM, sync write, registered read. It is inferable as distributed/block RAM.
- The FSM, counters and flags stay in the top.

Test Plan:
- Normal frame: arm=1; send 64 beats with tdata=0..63, tkeep=F, tlast on beat 63, tvalid continuous -> done=1 one cycle after the last beat; beat_count=64; all flags 0; rd_addr=10 gives rd_data=10 next cycle; checksum=2016 with the macro, 0 without.
- Short frame: tlast on beat 9 (10 beats) -> done=1, beat_count=10, length_error=1, overflow=0.
- Overflow: 70 beats with tlast on the 70th -> beat_count=70, overflow=1, length_error=1; buffer[63]=63; beats 64..69 not stored.
- Gapped valid and keep error: tvalid toggled every other cycle, beat 5 with tkeep=4'h7, 64 beats -> beat_count=64, keep_error=1, buffer[5] holds beat 5's data.
- Re-arm: after done, keep arm=1 and drive another frame -> s_tready stays 0 and nothing is accepted. Then arm=0 -> IDLE, done=0. Then arm=1 -> flags and count cleared and the second frame is captured.
- Reset mid-frame: reset=1 after 20 accepted beats -> next cycle s_tready=0, busy=0, beat_count=0, flags 0; a fresh arm then captures a full 64-beat frame correctly.
